// File: rtl/riscv_mem_pkg.sv
// Shared memory-port types and default widths for the RV64I core, the arbiter
// and the unified memory model.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and LSU: LSU first, but IF is forced through
// after MAX_LSU_STREAK consecutive LSU grants taken while IF was waiting.
module mem_arb_pick
  import riscv_mem_pkg::*;
#(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pick_en,
  input  logic if_valid,
  input  logic lsu_valid,
  output logic grant_if,
  output logic grant_lsu
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_LSU_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // Requesters hold valid until ready, so a grant is always an accept.
  always_comb begin
    grant_lsu = pick_en && lsu_valid && !(if_valid && (streak_q == MAX_S));
    grant_if  = pick_en && if_valid && !grant_lsu;
    streak_d  = streak_q;
    if (grant_if) begin
      streak_d = '0;
    end else if (grant_lsu) begin
      if (!if_valid) begin
        streak_d = '0;
      end else if (streak_q != MAX_S) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU with a single
// outstanding transaction: IDLE (arbitrate) -> REQ (present) -> RESP (route).
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                lsu_req_valid,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_we,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_req_ready,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                busy,
  output logic                proto_err
);

  localparam int STRB_W = DATA_W / 8;

  // Handshake rule on every port: a request transfers in the cycle where
  // valid && ready are both high; the requester holds valid and payload stable
  // until then. Responses are single-cycle pulses with no back-pressure.

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                proto_err_q, proto_err_d;

  logic pick_en;
  logic grant_if;
  logic grant_lsu;

  // Readies stay low while reset is asserted, even if a requester is valid.
  assign pick_en = rst_n && (state_q == IDLE);

  mem_arb_pick #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .pick_en   (pick_en),
    .if_valid  (if_req_valid),
    .lsu_valid (lsu_req_valid),
    .grant_if  (grant_if),
    .grant_lsu (grant_lsu)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    proto_err_d = proto_err_q | (mem_rsp_valid && (state_q != RESP));
    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          we_d    = lsu_req_we;
          wdata_d = lsu_req_wdata;
          wstrb_d = lsu_req_wstrb;
          state_d = REQ;
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = if_req_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign lsu_req_ready = grant_lsu;

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  assign if_rsp_valid  = (state_q == RESP) && mem_rsp_valid && (owner_q == OWN_IF);
  assign lsu_rsp_valid = (state_q == RESP) && mem_rsp_valid && (owner_q == OWN_LSU);
  assign if_rsp_data   = mem_rsp_rdata;
  assign lsu_rsp_rdata = mem_rsp_rdata;

  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// back-pressure run, all driven through one cycle engine with scoreboards.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SW   = DW / 8;
  localparam int MAXS = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
  logic [SW-1:0] lsu_req_wstrb;
  logic          mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_rdata;
  logic [SW-1:0] mem_req_wstrb;
  logic          busy, proto_err;

  mem_port_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .MAX_LSU_STREAK (MAXS)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .if_req_valid (if_req_valid), .if_req_addr (if_req_addr), .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid), .if_rsp_data (if_rsp_data),
    .lsu_req_valid (lsu_req_valid), .lsu_req_addr (lsu_req_addr), .lsu_req_we (lsu_req_we),
    .lsu_req_wdata (lsu_req_wdata), .lsu_req_wstrb (lsu_req_wstrb), .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid), .lsu_rsp_rdata (lsu_rsp_rdata),
    .mem_req_valid (mem_req_valid), .mem_req_addr (mem_req_addr), .mem_req_we (mem_req_we),
    .mem_req_wdata (mem_req_wdata), .mem_req_wstrb (mem_req_wstrb), .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid), .mem_rsp_rdata (mem_rsp_rdata),
    .busy (busy), .proto_err (proto_err)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- model state / scoreboards ----------------
  // req entry: {owner, we, wstrb[7:0], addr[63:0], wdata[63:0]}
  logic [137:0] req_q[$];
  // expected response: {we, owner, data[63:0]}
  logic [65:0]  exp_q[$];
  bit           grant_log[$];   // 1 = LSU grant, 0 = IF grant

  int  m_phase   = 0;           // 0 idle, 1 request presented, 2 awaiting response
  int  m_streak  = 0;
  int  rsp_wait  = 0;
  int  stall_left = 0;
  int  ready_pct = 100;
  int  lat_min   = 1;
  int  lat_max   = 1;
  bit  stray_req = 0;
  bit  exp_proto = 0;
  int  cyc = 0, acc_cyc = 0, last_lat = 0;
  int  rsp_count = 0, lsu_rsp_cnt = 0;
  logic [63:0] pend_data = '0;
  logic [63:0] last_if_data = '0;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h13;
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  task automatic reset_model();
    req_q.delete();
    exp_q.delete();
    m_phase = 0; m_streak = 0; rsp_wait = 0; stall_left = 0;
    stray_req = 0; exp_proto = 0;
  endtask

  // One clock cycle. Entered and left at posedge+1 with requester inputs set.
  task automatic step();
    logic        acc_if, acc_lsu, e_if_rdy, e_lsu_rdy, e_if_rsp, e_lsu_rsp, proto_next;
    logic [137:0] r;
    logic [65:0]  e;
    int           next_phase;
    // memory model drives its side
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = {$urandom, $urandom};
    if (m_phase == 2) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = pend_data;
      end
    end else if (m_phase == 0 && stray_req) begin
      mem_rsp_valid = 1'b1;
      stray_req = 0;
    end
    if (m_phase == 1 && stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
    end else begin
      mem_req_ready = ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    next_phase = m_phase;
    proto_next = exp_proto;
    e_lsu_rdy = 1'b0;
    e_if_rdy  = 1'b0;
    if (m_phase == 0) begin
      e_lsu_rdy = lsu_req_valid && !(if_req_valid && m_streak == MAXS);
      e_if_rdy  = if_req_valid && !e_lsu_rdy;
    end
    check("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
    check("lsu_req_ready", 64'(lsu_req_ready), 64'(e_lsu_rdy));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("mem_req_valid", 64'(mem_req_valid), 64'(m_phase == 1));
    check("proto_err", 64'(proto_err), 64'(exp_proto));
    acc_if  = if_req_valid && if_req_ready;
    acc_lsu = lsu_req_valid && lsu_req_ready;
    if (acc_lsu) begin
      req_q.push_back({1'b1, lsu_req_we, lsu_req_wstrb, lsu_req_addr, lsu_req_wdata});
      m_streak = if_req_valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      grant_log.push_back(1'b1);
    end else if (acc_if) begin
      req_q.push_back({1'b0, 1'b0, 8'h00, if_req_addr, 64'h0});
      m_streak = 0;
      grant_log.push_back(1'b0);
    end
    if (acc_if || acc_lsu) begin
      acc_cyc = cyc;
      next_phase = 1;
    end
    if (m_phase == 1 && req_q.size() > 0) begin
      r = req_q[0];
      check("mem_req_addr", mem_req_addr, r[127:64]);
      check("mem_req_we", 64'(mem_req_we), 64'(r[136]));
      check("mem_req_wstrb", 64'(mem_req_wstrb), 64'(r[135:128]));
      if (r[137]) check("mem_req_wdata", mem_req_wdata, r[63:0]);
      if (mem_req_ready) begin
        void'(req_q.pop_front());
        pend_data = mem_data(r[127:64]);
        exp_q.push_back({r[136], r[137], pend_data});
        rsp_wait = $urandom_range(lat_min, lat_max);
        next_phase = 2;
      end
    end
    e_if_rsp  = 1'b0;
    e_lsu_rsp = 1'b0;
    if (m_phase == 2 && mem_rsp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_lsu_rsp = e[64];
      e_if_rsp  = !e[64];
      if (!e[65]) begin
        if (e[64]) check("lsu_rsp_rdata", lsu_rsp_rdata, e[63:0]);
        else       check("if_rsp_data", if_rsp_data, e[63:0]);
      end
      last_lat = cyc - acc_cyc;
      next_phase = 0;
      rsp_count++;
    end
    if (mem_rsp_valid && m_phase != 2) proto_next = 1'b1;
    check("if_rsp_valid", 64'(if_rsp_valid), 64'(e_if_rsp));
    check("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(e_lsu_rsp));
    if (if_rsp_valid) last_if_data = if_rsp_data;
    if (lsu_rsp_valid) lsu_rsp_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    m_phase   = next_phase;
    exp_proto = proto_next;
    if (acc_if)  if_req_valid  = 1'b0;
    if (acc_lsu) lsu_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int start = rsp_count;
    int k = 0;
    while ((rsp_count - start) < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(rsp_count - start), 64'(n));
  endtask

  task automatic raise_lsu(input logic [63:0] a, input logic we, input logic [63:0] wd,
                           input logic [7:0] ws);
    lsu_req_valid = 1'b1;
    lsu_req_addr  = a;
    lsu_req_we    = we;
    lsu_req_wdata = wd;
    lsu_req_wstrb = ws;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, issued, start, n_lsu;
    if_req_valid = 0; if_req_addr = '0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_we = 0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_req_addr", mem_req_addr, 64'd0);
    check("rst_mem_req_wdata", mem_req_wdata, 64'd0);
    check("rst_mem_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    rst_n = 1'b1;

    // IF-only fetch with immediate memory
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0000;
    wait_rsp("t2_done", 1, 20);
    check("t2_latency", 64'(last_lat), 64'd2);
    check("t2_data", last_if_data, 64'h13);

    // simultaneous IF and LSU load
    grant_log.delete();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0008;
    raise_lsu(64'h1000, 1'b0, 64'h0, 8'h00);
    wait_rsp("t3_done", 2, 30);
    check("t3_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("t3_first_lsu", 64'(grant_log[0]), 64'd1);
      check("t3_second_if", 64'(grant_log[1]), 64'd0);
    end

    // IF starvation limit under back-to-back LSU traffic
    grant_log.delete();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0010;
    k = 0;
    while (if_req_valid && k < 200) begin
      if (!lsu_req_valid) raise_lsu(64'h3000 + 64'(k) * 8, 1'b0, 64'h0, 8'h00);
      step();
      k++;
    end
    n_lsu = 0;
    foreach (grant_log[i]) if (grant_log[i]) n_lsu++;
    check("t4_lsu_before_if", 64'(n_lsu), 64'(MAXS));
    check("t4_if_granted", 64'(if_req_valid), 64'd0);
    k = 0;
    while ((lsu_req_valid || m_phase != 0) && k < 100) begin
      step();
      k++;
    end
    check("t4_drained", 64'(m_phase), 64'd0);

    // store with memory back-pressure, then a stray response
    start = lsu_rsp_cnt;
    raise_lsu(64'h2000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
    stall_left = 3;
    wait_rsp("t5_done", 1, 30);
    check("t5_lsu_ack", 64'(lsu_rsp_cnt - start), 64'd1);
    check("t5_latency", 64'(last_lat), 64'd5);
    stray_req = 1;
    step();
    step();
    check("t5_proto_set", 64'(proto_err), 64'd1);
    repeat (3) step();
    check("t5_proto_sticky", 64'(proto_err), 64'd1);

    // reset in the middle of a request
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0020;
    stall_left = 10;
    k = 0;
    while (m_phase != 1 && k < 10) begin
      step();
      k++;
    end
    step();
    if_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t1_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_if_ready", 64'(if_req_ready), 64'd0);
    check("t1_lsu_ready", 64'(lsu_req_ready), 64'd0);
    check("t1_proto_err", 64'(proto_err), 64'd0);
    check("t1_if_rsp", 64'(if_rsp_valid), 64'd0);
    reset_model();
    if_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random traffic, back-pressure and latency
    ready_pct = 60;
    lat_min = 1;
    lat_max = 8;
    issued = 0;
    start = rsp_count;
    k = 0;
    while ((rsp_count - start) < 1000 && k < 60000) begin
      if (!if_req_valid && issued < 1000 && $urandom_range(0, 2) == 0) begin
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 8;
        issued++;
      end
      if (!lsu_req_valid && issued < 1000 && $urandom_range(0, 2) == 0) begin
        raise_lsu(64'($urandom_range(0, 65535)) * 8, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        issued++;
      end
      step();
      k++;
    end
    check("t6_responses", 64'(rsp_count - start), 64'd1000);
    check("t6_req_q_empty", 64'(req_q.size()), 64'd0);
    check("t6_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("t6_proto_clean", 64'(proto_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
